// File: rtl/pq_pkg.sv
// Shared types for the QuickQ priority-queue node chain and its host command controller.
package pq_pkg;

  localparam int KEY_W = 32;
  localparam int VAL_W = 16;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [VAL_W-1:0] val;
  } kv_t;

  // All-ones key marks an empty node slot, so it can never be stored as real data.
  localparam logic [KEY_W-1:0] MAX_KEY = '1;

  typedef enum logic [1:0] {
    QQ_NOP  = 2'b00,
    QQ_ENQ  = 2'b01,
    QQ_DEQ  = 2'b10,
    QQ_REPL = 2'b11
  } qq_op_t;

  typedef enum logic [2:0] {
    QQ_OK        = 3'd0,
    QQ_E_EMPTY   = 3'd1,
    QQ_E_FULL    = 3'd2,
    QQ_E_BADKEY  = 3'd3,
    QQ_E_TIMEOUT = 3'd4
  } qq_err_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_GUARD,
    S_WAIT,
    S_RESP
  } qq_state_t;

  function automatic logic op_carries_key(input qq_op_t op);
    return (op == QQ_ENQ) || (op == QQ_REPL);
  endfunction

endpackage

// File: rtl/qq_cmd_ctrl.sv
// Host-side initiator for the QuickQ node chain: turns valid/ready requests into single-cycle
// node command pulses and returns one response (head kv or error) per accepted request.
module qq_cmd_ctrl
  import pq_pkg::*;
#(
  parameter int W       = KEY_W,
  parameter int CAP     = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  qq_op_t                     req_op,
  input  kv_t                        req_kv,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output kv_t                        rsp_kv,
  output qq_err_t                    rsp_err,
  output logic                       q_enq,
  output logic                       q_deq,
  output logic                       q_repl,
  output kv_t                        q_kv,
  input  logic                       q_rdy,
  input  kv_t                        q_head,
  input  logic                       q_full,
  input  logic                       q_empty,
  output logic [$clog2(CAP+1)-1:0]   occ
);

  localparam int OCC_W = $clog2(CAP + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(CAP);
  localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

  qq_state_t         state_q;
  qq_op_t            op_q;
  kv_t               kv_q;
  kv_t               head_q;
  logic [TO_W-1:0]   wait_cnt_q;
  logic [OCC_W-1:0]  occ_q;
  logic              req_ready_q;
  logic              rsp_valid_q;
  kv_t               rsp_kv_q;
  qq_err_t           rsp_err_q;
  logic              q_enq_q;
  logic              q_deq_q;
  logic              q_repl_q;
  kv_t               q_kv_q;

  logic bad_key;
  assign bad_key = (op_q == QQ_NOP) ||
                   (op_carries_key(op_q) && (kv_q.key[W-1:0] == MAX_KEY[W-1:0]));

  // NOTE: every state register here is written with <= so all updates in a cycle see
  // the pre-edge values; a blocking = would leak new values into later statements.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= QQ_NOP;
      kv_q        <= '0;
      head_q      <= '0;
      wait_cnt_q  <= '0;
      occ_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_kv_q    <= '0;
      rsp_err_q   <= QQ_OK;
      q_enq_q     <= 1'b0;
      q_deq_q     <= 1'b0;
      q_repl_q    <= 1'b0;
      q_kv_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            op_q        <= req_op;
            kv_q        <= req_kv;
            req_ready_q <= 1'b0;
            wait_cnt_q  <= '0;
            state_q     <= S_CHECK;
          end
        end

        // Node flags are only trustworthy while the node reports ready.
        S_CHECK: begin
          if (q_rdy) begin
            wait_cnt_q <= '0;
            if (bad_key) begin
              rsp_err_q   <= QQ_E_BADKEY;
              rsp_kv_q    <= '0;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else if ((op_q != QQ_ENQ) && q_empty) begin
              rsp_err_q   <= QQ_E_EMPTY;
              rsp_kv_q    <= '0;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else if ((op_q == QQ_ENQ) && q_full) begin
              rsp_err_q   <= QQ_E_FULL;
              rsp_kv_q    <= '0;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              head_q   <= q_head;
              q_kv_q   <= kv_q;
              q_enq_q  <= (op_q == QQ_ENQ);
              q_deq_q  <= (op_q == QQ_DEQ);
              q_repl_q <= (op_q == QQ_REPL);
              state_q  <= S_ISSUE;
            end
          end else if (wait_cnt_q == TO_LAST) begin
            rsp_err_q   <= QQ_E_TIMEOUT;
            rsp_kv_q    <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end

        S_ISSUE: begin
          q_enq_q  <= 1'b0;
          q_deq_q  <= 1'b0;
          q_repl_q <= 1'b0;
          state_q  <= S_GUARD;
        end

        // The node drops rdy only after sampling the pulse, so rdy is stale for one cycle.
        S_GUARD: begin
          wait_cnt_q <= '0;
          state_q    <= S_WAIT;
        end

        S_WAIT: begin
          if (q_rdy) begin
            rsp_err_q   <= QQ_OK;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
            if (op_q == QQ_ENQ) begin
              rsp_kv_q <= '0;
            end else begin
              rsp_kv_q <= head_q;
            end
            if ((op_q == QQ_ENQ) && (occ_q != OCC_MAX)) begin
              occ_q <= occ_q + 1'b1;
            end else if ((op_q == QQ_DEQ) && (occ_q != '0)) begin
              occ_q <= occ_q - 1'b1;
            end
          end else if (wait_cnt_q == TO_LAST) begin
            rsp_err_q   <= QQ_E_TIMEOUT;
            rsp_kv_q    <= '0;
            rsp_valid_q <= 1'b1;
            state_q     <= S_RESP;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end

        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_kv    = rsp_kv_q;
  assign rsp_err   = rsp_err_q;
  assign q_enq     = q_enq_q;
  assign q_deq     = q_deq_q;
  assign q_repl    = q_repl_q;
  assign q_kv      = q_kv_q;
  assign occ       = occ_q;

endmodule

// File: tb/tb_qq_cmd_ctrl.sv
// Self-checking bench for qq_cmd_ctrl: behavioural node chain plus a reference queue and scoreboard.
module tb_qq_cmd_ctrl;
  import pq_pkg::*;

  localparam int CAP     = 4;
  localparam int TIMEOUT = 64;
  localparam int OCC_W   = $clog2(CAP + 1);
  localparam int LIMIT   = 300;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  qq_op_t            req_op;
  kv_t               req_kv;
  logic              rsp_valid;
  logic              rsp_ready;
  kv_t               rsp_kv;
  qq_err_t           rsp_err;
  logic              q_enq;
  logic              q_deq;
  logic              q_repl;
  kv_t               q_kv;
  logic              q_rdy;
  kv_t               q_head;
  logic              q_full;
  logic              q_empty;
  logic [OCC_W-1:0]  occ;

  always #5 clk = ~clk;

  qq_cmd_ctrl #(.W(KEY_W), .CAP(CAP), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_kv(req_kv),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_kv(rsp_kv), .rsp_err(rsp_err),
    .q_enq(q_enq), .q_deq(q_deq), .q_repl(q_repl), .q_kv(q_kv),
    .q_rdy(q_rdy), .q_head(q_head), .q_full(q_full), .q_empty(q_empty),
    .occ(occ)
  );

  // Behavioural node chain: sorted entries, busy for node_lat cycles after each command.
  kv_t [CAP-1:0] mem_q, mem_d;
  int            cnt_q, cnt_d;
  int            busy_q;
  int            node_lat;

  always_comb begin
    kv_t tmp;
    tmp   = '0;
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (q_enq && cnt_q < CAP) begin
      mem_d[cnt_q] = q_kv;
      cnt_d = cnt_q + 1;
      for (int i = CAP - 1; i > 0; i--) begin
        if (i < cnt_d && mem_d[i].key < mem_d[i-1].key) begin
          tmp = mem_d[i]; mem_d[i] = mem_d[i-1]; mem_d[i-1] = tmp;
        end
      end
    end else if (q_deq && cnt_q > 0) begin
      for (int i = 0; i < CAP - 1; i++) mem_d[i] = mem_q[i+1];
      mem_d[CAP-1] = '1;
      cnt_d = cnt_q - 1;
    end else if (q_repl && cnt_q > 0) begin
      mem_d[0] = q_kv;
      for (int i = 0; i < CAP - 1; i++) begin
        if (i + 1 < cnt_q && mem_d[i+1].key < mem_d[i].key) begin
          tmp = mem_d[i]; mem_d[i] = mem_d[i+1]; mem_d[i+1] = tmp;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      mem_q  <= '1;
      cnt_q  <= 0;
      busy_q <= 0;
    end else begin
      mem_q <= mem_d;
      cnt_q <= cnt_d;
      if (q_enq || q_deq || q_repl) busy_q <= node_lat;
      else if (busy_q > 0)          busy_q <= busy_q - 1;
    end
  end

  assign q_rdy   = (busy_q == 0);
  assign q_head  = mem_q[0];
  assign q_empty = (cnt_q == 0);
  assign q_full  = (cnt_q == CAP);

  // Monitors: pulse counts/widths, issue-to-response latency, response handshakes.
  int cyc = 0;
  int enq_cnt = 0, deq_cnt = 0, repl_cnt = 0, width_err = 0, rsp_hs = 0;
  int issue_cyc = 0, rise_cyc = 0;
  logic enq_prev = 1'b0, deq_prev = 1'b0, repl_prev = 1'b0, rsp_prev = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && rsp_valid && rsp_ready) rsp_hs <= rsp_hs + 1;
  end

  always @(negedge clk) begin
    if (q_enq)  enq_cnt  <= enq_cnt + 1;
    if (q_deq)  deq_cnt  <= deq_cnt + 1;
    if (q_repl) repl_cnt <= repl_cnt + 1;
    if ((q_enq && enq_prev) || (q_deq && deq_prev) || (q_repl && repl_prev)) width_err <= width_err + 1;
    if (q_enq || q_deq || q_repl) issue_cyc <= cyc;
    if (rsp_valid && !rsp_prev)   rise_cyc  <= cyc;
    enq_prev  <= q_enq;
    deq_prev  <= q_deq;
    repl_prev <= q_repl;
    rsp_prev  <= rsp_valid;
  end

  // Reference model and scoreboard.
  typedef struct {
    qq_err_t err;
    kv_t     kv;
    int      occ;
    int      enq;
    int      deq;
    int      repl;
  } exp_t;

  kv_t  ref_q[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_runs   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic kv_t mk(input int k, input int v);
    kv_t r;
    r.key = k;
    r.val = v[15:0];
    return r;
  endfunction

  task automatic ref_insert(input kv_t kv);
    int i = 0;
    while (i < ref_q.size() && ref_q[i].key <= kv.key) i++;
    ref_q.insert(i, kv);
  endtask

  task automatic predict(input qq_op_t op, input kv_t kv, input bit to, output exp_t e);
    e.err = QQ_OK; e.kv = '0; e.enq = 0; e.deq = 0; e.repl = 0;
    if (op == QQ_NOP || ((op == QQ_ENQ || op == QQ_REPL) && kv.key == '1)) begin
      e.err = QQ_E_BADKEY;
    end else if (op != QQ_ENQ && ref_q.size() == 0) begin
      e.err = QQ_E_EMPTY;
    end else if (op == QQ_ENQ && ref_q.size() == CAP) begin
      e.err = QQ_E_FULL;
    end else begin
      e.enq  = (op == QQ_ENQ);
      e.deq  = (op == QQ_DEQ);
      e.repl = (op == QQ_REPL);
      if (to) begin
        e.err = QQ_E_TIMEOUT;
      end else if (op == QQ_ENQ) begin
        ref_insert(kv);
      end else begin
        e.kv = ref_q.pop_front();
        if (op == QQ_REPL) ref_insert(kv);
      end
    end
    e.occ = ref_q.size();
  endtask

  task automatic send(input string tag, input qq_op_t op, input kv_t kv);
    int n = 0;
    req_valid = 1'b1; req_op = op; req_kv = kv;
    while (!req_ready && n < LIMIT) begin @(negedge clk); n++; end
    if (!req_ready) check({tag, "_req_ready_timeout"}, 0, 1);
    @(negedge clk);
    req_valid = 1'b0; req_op = QQ_NOP; req_kv = '0;
  endtask

  task automatic run(input string tag, input qq_op_t op, input kv_t kv, input bit to, input int hold);
    exp_t e, got;
    int   n, bad, e0, d0, r0;
    kv_t  kv0;
    e0 = enq_cnt; d0 = deq_cnt; r0 = repl_cnt;
    predict(op, kv, to, e);
    sb.push_back(e);
    n_runs++;
    rsp_ready = (hold == 0);
    send(tag, op, kv);
    n = 0;
    while (!rsp_valid && n < LIMIT) begin @(negedge clk); n++; end
    if (!rsp_valid) begin
      check({tag, "_rsp_timeout"}, 0, 1);
      void'(sb.pop_front());
      rsp_ready = 1'b1;
      return;
    end
    if (hold > 0) begin
      kv0 = rsp_kv;
      bad = 0;
      repeat (hold) begin
        @(negedge clk);
        if (!rsp_valid || rsp_kv != kv0 || req_ready) bad++;
      end
      check({tag, "_hold_stable"}, bad, 0);
      rsp_ready = 1'b1;
    end
    got = sb.pop_front();
    check({tag, "_err"}, rsp_err, got.err);
    check({tag, "_kv"},  rsp_kv,  got.kv);
    check({tag, "_occ"}, occ,     got.occ);
    @(negedge clk);
    check({tag, "_rsp_drop"}, rsp_valid, 0);
    check({tag, "_pulses"}, {8'(enq_cnt - e0), 8'(deq_cnt - d0), 8'(repl_cnt - r0)},
                            {8'(got.enq), 8'(got.deq), 8'(got.repl)});
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_kv"},    rsp_kv,    0);
    check({tag, "_rsp_err"},   rsp_err,   QQ_OK);
    check({tag, "_pulses"},    {q_enq, q_deq, q_repl}, 0);
    check({tag, "_q_kv"},      q_kv,      0);
    check({tag, "_occ"},       occ,       0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst = 1'b1; req_valid = 1'b0; req_op = QQ_NOP; req_kv = '0; rsp_ready = 1'b1; node_lat = 1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    run("enq5", QQ_ENQ, mk(5, 16'h0105), 1'b0, 0);
    run("enq3", QQ_ENQ, mk(3, 16'h0103), 1'b0, 0);
    node_lat = 3;
    run("enq9", QQ_ENQ, mk(9, 16'h0109), 1'b0, 0);
    run("deq_a", QQ_DEQ, mk(0, 0), 1'b0, 0);
    run("deq_b", QQ_DEQ, mk(0, 0), 1'b0, 0);
    node_lat = 1;
    run("deq_c", QQ_DEQ, mk(0, 0), 1'b0, 0);
    run("deq_empty", QQ_DEQ, mk(0, 0), 1'b0, 0);
    run("repl_empty", QQ_REPL, mk(2, 16'h0202), 1'b0, 0);

    run("fill4", QQ_ENQ, mk(4, 16'h0204), 1'b0, 0);
    run("fill8", QQ_ENQ, mk(8, 16'h0208), 1'b0, 0);
    run("fill2", QQ_ENQ, mk(2, 16'h0202), 1'b0, 0);
    run("fill6", QQ_ENQ, mk(6, 16'h0206), 1'b0, 0);
    run("enq_full", QQ_ENQ, mk(7, 16'h0207), 1'b0, 0);
    run("repl1", QQ_REPL, mk(1, 16'h0301), 1'b0, 0);
    run("deq_after_repl", QQ_DEQ, mk(0, 0), 1'b0, 0);

    run("enq_maxkey", QQ_ENQ, mk(-1, 16'h0400), 1'b0, 0);
    run("repl_maxkey", QQ_REPL, mk(-1, 16'h0401), 1'b0, 0);
    run("nop", QQ_NOP, mk(12, 16'h0402), 1'b0, 0);

    run("deq_hold", QQ_DEQ, mk(0, 0), 1'b0, 10);
    node_lat = 3;
    run("repl5", QQ_REPL, mk(5, 16'h0505), 1'b0, 0);

    node_lat = 70;
    run("timeout", QQ_ENQ, mk(10, 16'h0610), 1'b1, 0);
    check("timeout_latency", rise_cyc - issue_cyc, 2 + TIMEOUT);

    // Reset while the controller waits on a slow node: no response may follow.
    node_lat = 20;
    send("rst_wait", QQ_ENQ, mk(11, 16'h0711));
    n = 0;
    while (!q_enq && n < LIMIT) begin @(negedge clk); n++; end
    check("rst_wait_issue", q_enq, 1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_wait");
    rst = 1'b0;
    ref_q.delete();
    n = 0;
    repeat (12) begin @(negedge clk); if (rsp_valid) n++; end
    check("rst_wait_no_rsp", n, 0);

    node_lat = 1;
    run("post_rst_enq", QQ_ENQ, mk(12, 16'h0812), 1'b0, 0);
    run("post_rst_deq", QQ_DEQ, mk(0, 0), 1'b0, 0);

    repeat (2) @(negedge clk);
    check("pulse_width", width_err, 0);
    check("rsp_count", rsp_hs, n_runs);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
